alu_reservation_station: RTL and testbench

Reservation station directly upstream of the ALU. Buffers issued ALU/branch micro-ops, wakes waiting operands from the ALU and LSB result broadcasts (CDB), and dispatches one ready entry per cycle to the ALU as a registered status/OpCode/rs1/rs2/ROB_Number bundle. Flushed by the global clear on mispredict.

---
 rtl/alu_reservation_station_pkg.sv | 60 ++++++
 rtl/alu_reservation_station_rs_priority_enc.sv | 23 ++
 rtl/alu_reservation_station.sv | 167 ++++++++++++++++
 tb/tb_alu_reservation_station.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_reservation_station_pkg.sv
// Shared types, widths and opcode constants for the ALU reservation station.
// Also holds the CDB snoop helper used by both the issue path and the entry wakeup.
package alu_reservation_station_pkg;

  localparam int RS_SIZE = 16;
  localparam int IDX_W   = 4;
  localparam int OP_W    = 6;
  localparam int TAG_W   = 5;
  localparam int DATA_W  = 32;

  localparam logic [OP_W-1:0] OP_NOP  = 6'd0;
  localparam logic [OP_W-1:0] OP_ADD  = 6'd1;
  localparam logic [OP_W-1:0] OP_SUB  = 6'd2;
  localparam logic [OP_W-1:0] OP_ADDI = 6'd3;
  localparam logic [OP_W-1:0] OP_BEQ  = 6'd4;

  typedef struct packed {
    logic              busy;
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] vj;
    logic [TAG_W-1:0]  qj;
    logic              rj;
    logic [DATA_W-1:0] vk;
    logic [TAG_W-1:0]  qk;
    logic              rk;
    logic [TAG_W-1:0]  dest;
  } rs_entry_t;

  typedef struct packed {
    logic [DATA_W-1:0] val;
    logic              rdy;
  } operand_t;

  // A pending operand takes the ALU broadcast first; identical ALU/LSB tags never occur legally.
  function automatic operand_t snoop_operand(
    input logic [DATA_W-1:0] val,
    input logic [TAG_W-1:0]  tag,
    input logic              rdy,
    input logic              a_valid,
    input logic [TAG_W-1:0]  a_tag,
    input logic [DATA_W-1:0] a_val,
    input logic              l_valid,
    input logic [TAG_W-1:0]  l_tag,
    input logic [DATA_W-1:0] l_val
  );
    operand_t res;
    if (!rdy && a_valid && (a_tag == tag)) begin
      res.val = a_val;
      res.rdy = 1'b1;
    end else if (!rdy && l_valid && (l_tag == tag)) begin
      res.val = l_val;
      res.rdy = 1'b1;
    end else begin
      res.val = val;
      res.rdy = rdy;
    end
    return res;
  endfunction

endpackage

// File: rtl/alu_reservation_station_rs_priority_enc.sv
// Lowest-set-bit finder over the station's entry vector; purely combinational.
module rs_priority_enc
  import alu_reservation_station_pkg::*;
#(
  parameter int N = RS_SIZE,
  parameter int W = IDX_W
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         found
);

  // Scan from the top so the lowest requesting index wins last.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      idx   = req[i] ? W'(i) : idx;
      found = found | req[i];
    end
  end

endmodule

// File: rtl/alu_reservation_station.sv
// Reservation station ahead of the ALU: buffers issued micro-ops, snoops both CDBs,
// and sends the lowest-index ready entry to the ALU each cycle through registered outputs.
module alu_reservation_station
  import alu_reservation_station_pkg::*;
(
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              clear,
  input  logic              issue_valid,
  input  logic [OP_W-1:0]   issue_op,
  input  logic [DATA_W-1:0] issue_vj,
  input  logic [TAG_W-1:0]  issue_qj,
  input  logic              issue_qj_busy,
  input  logic [DATA_W-1:0] issue_vk,
  input  logic [TAG_W-1:0]  issue_qk,
  input  logic              issue_qk_busy,
  input  logic [TAG_W-1:0]  issue_dest,
  output logic              rs_full,
  input  logic              alu_cdb_valid,
  input  logic [TAG_W-1:0]  alu_cdb_tag,
  input  logic [DATA_W-1:0] alu_cdb_val,
  input  logic              lsb_cdb_valid,
  input  logic [TAG_W-1:0]  lsb_cdb_tag,
  input  logic [DATA_W-1:0] lsb_cdb_val,
  output logic              alu_status,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] alu_rs1,
  output logic [DATA_W-1:0] alu_rs2,
  output logic [TAG_W-1:0]  alu_rob
);

  rs_entry_t          ent_r     [RS_SIZE];
  rs_entry_t          ent_nxt_s [RS_SIZE];
  rs_entry_t          issue_ent_s;
  operand_t           issue_j_s;
  operand_t           issue_k_s;
  logic [RS_SIZE-1:0] busy_vec_s;
  logic [RS_SIZE-1:0] ready_vec_s;
  logic [RS_SIZE-1:0] free_vec_s;
  logic [RS_SIZE-1:0] busy_nxt_s;
  logic [IDX_W-1:0]   free_idx_s;
  logic [IDX_W-1:0]   disp_idx_s;
  logic               free_found_s;
  logic               disp_found_s;
  logic               do_issue_s;

  logic               rs_full_r;
  logic               alu_status_r;
  logic [OP_W-1:0]    alu_op_r;
  logic [DATA_W-1:0]  alu_rs1_r;
  logic [DATA_W-1:0]  alu_rs2_r;
  logic [TAG_W-1:0]   alu_rob_r;

  // Occupancy and readiness vectors from the pre-edge entry state.
  always_comb begin
    busy_vec_s  = '0;
    ready_vec_s = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      busy_vec_s[i]  = ent_r[i].busy;
      ready_vec_s[i] = ent_r[i].busy & ent_r[i].rj & ent_r[i].rk;
    end
    free_vec_s = ~busy_vec_s;
  end

  rs_priority_enc #(.N(RS_SIZE), .W(IDX_W)) u_free_enc (
    .req   (free_vec_s),
    .idx   (free_idx_s),
    .found (free_found_s)
  );

  rs_priority_enc #(.N(RS_SIZE), .W(IDX_W)) u_ready_enc (
    .req   (ready_vec_s),
    .idx   (disp_idx_s),
    .found (disp_found_s)
  );

  assign issue_j_s = snoop_operand(issue_vj, issue_qj, ~issue_qj_busy,
                                   alu_cdb_valid, alu_cdb_tag, alu_cdb_val,
                                   lsb_cdb_valid, lsb_cdb_tag, lsb_cdb_val);
  assign issue_k_s = snoop_operand(issue_vk, issue_qk, ~issue_qk_busy,
                                   alu_cdb_valid, alu_cdb_tag, alu_cdb_val,
                                   lsb_cdb_valid, lsb_cdb_tag, lsb_cdb_val);

  // Free slot comes from pre-edge occupancy, so a slot vacated by dispatch is not refilled this edge.
  assign do_issue_s = issue_valid & free_found_s & ~rs_full_r;

  // Assemble the entry written on issue, with same-cycle CDB forwarding applied.
  always_comb begin
    issue_ent_s      = '0;
    issue_ent_s.busy = 1'b1;
    issue_ent_s.op   = issue_op;
    issue_ent_s.vj   = issue_j_s.val;
    issue_ent_s.qj   = issue_qj;
    issue_ent_s.rj   = issue_j_s.rdy;
    issue_ent_s.vk   = issue_k_s.val;
    issue_ent_s.qk   = issue_qk;
    issue_ent_s.rk   = issue_k_s.rdy;
    issue_ent_s.dest = issue_dest;
  end

  // Next entry state: wakeup on busy entries, release of the dispatched entry, then issue write.
  always_comb begin
    operand_t wake_j;
    operand_t wake_k;
    wake_j     = '0;
    wake_k     = '0;
    busy_nxt_s = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      wake_j = snoop_operand(ent_r[i].vj, ent_r[i].qj, ent_r[i].rj,
                             alu_cdb_valid, alu_cdb_tag, alu_cdb_val,
                             lsb_cdb_valid, lsb_cdb_tag, lsb_cdb_val);
      wake_k = snoop_operand(ent_r[i].vk, ent_r[i].qk, ent_r[i].rk,
                             alu_cdb_valid, alu_cdb_tag, alu_cdb_val,
                             lsb_cdb_valid, lsb_cdb_tag, lsb_cdb_val);
      ent_nxt_s[i]      = ent_r[i];
      ent_nxt_s[i].vj   = ent_r[i].busy ? wake_j.val : ent_r[i].vj;
      ent_nxt_s[i].rj   = ent_r[i].busy ? wake_j.rdy : ent_r[i].rj;
      ent_nxt_s[i].vk   = ent_r[i].busy ? wake_k.val : ent_r[i].vk;
      ent_nxt_s[i].rk   = ent_r[i].busy ? wake_k.rdy : ent_r[i].rk;
      ent_nxt_s[i].busy = ent_r[i].busy & ~(disp_found_s && (disp_idx_s == IDX_W'(i)));
      ent_nxt_s[i]      = (do_issue_s && (free_idx_s == IDX_W'(i))) ? issue_ent_s : ent_nxt_s[i];
      busy_nxt_s[i]     = ent_nxt_s[i].busy;
    end
  end

  // Entry array and dispatch registers; clear beats the rdy_in freeze.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        ent_r[i] <= '0;
      end
      rs_full_r    <= 1'b0;
      alu_status_r <= 1'b0;
      alu_op_r     <= '0;
      alu_rs1_r    <= '0;
      alu_rs2_r    <= '0;
      alu_rob_r    <= '0;
    end else if (clear) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        ent_r[i].busy <= 1'b0;
      end
      rs_full_r    <= 1'b0;
      alu_status_r <= 1'b0;
    end else if (rdy_in) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        ent_r[i] <= ent_nxt_s[i];
      end
      rs_full_r    <= &busy_nxt_s;
      alu_status_r <= disp_found_s;
      if (disp_found_s) begin
        alu_op_r  <= ent_r[disp_idx_s].op;
        alu_rs1_r <= ent_r[disp_idx_s].vj;
        alu_rs2_r <= ent_r[disp_idx_s].vk;
        alu_rob_r <= ent_r[disp_idx_s].dest;
      end
    end
  end

  assign rs_full    = rs_full_r;
  assign alu_status = alu_status_r;
  assign alu_op     = alu_op_r;
  assign alu_rs1    = alu_rs1_r;
  assign alu_rs2    = alu_rs2_r;
  assign alu_rob    = alu_rob_r;

endmodule

// File: tb/tb_alu_reservation_station.sv
// Self-checking bench for alu_reservation_station: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a behavioural model.
module tb_alu_reservation_station;
  import alu_reservation_station_pkg::*;

  logic              clk_in = 1'b0;
  logic              rst_in;
  logic              rdy_in;
  logic              clear;
  logic              issue_valid;
  logic [OP_W-1:0]   issue_op;
  logic [DATA_W-1:0] issue_vj;
  logic [TAG_W-1:0]  issue_qj;
  logic              issue_qj_busy;
  logic [DATA_W-1:0] issue_vk;
  logic [TAG_W-1:0]  issue_qk;
  logic              issue_qk_busy;
  logic [TAG_W-1:0]  issue_dest;
  logic              rs_full;
  logic              alu_cdb_valid;
  logic [TAG_W-1:0]  alu_cdb_tag;
  logic [DATA_W-1:0] alu_cdb_val;
  logic              lsb_cdb_valid;
  logic [TAG_W-1:0]  lsb_cdb_tag;
  logic [DATA_W-1:0] lsb_cdb_val;
  logic              alu_status;
  logic [OP_W-1:0]   alu_op;
  logic [DATA_W-1:0] alu_rs1;
  logic [DATA_W-1:0] alu_rs2;
  logic [TAG_W-1:0]  alu_rob;

  alu_reservation_station dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .issue_valid(issue_valid), .issue_op(issue_op),
    .issue_vj(issue_vj), .issue_qj(issue_qj), .issue_qj_busy(issue_qj_busy),
    .issue_vk(issue_vk), .issue_qk(issue_qk), .issue_qk_busy(issue_qk_busy),
    .issue_dest(issue_dest), .rs_full(rs_full),
    .alu_cdb_valid(alu_cdb_valid), .alu_cdb_tag(alu_cdb_tag), .alu_cdb_val(alu_cdb_val),
    .lsb_cdb_valid(lsb_cdb_valid), .lsb_cdb_tag(lsb_cdb_tag), .lsb_cdb_val(lsb_cdb_val),
    .alu_status(alu_status), .alu_op(alu_op), .alu_rs1(alu_rs1),
    .alu_rs2(alu_rs2), .alu_rob(alu_rob)
  );

  initial forever #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a table of waiting micro-ops.
  bit                m_busy [RS_SIZE];
  logic [OP_W-1:0]   m_op   [RS_SIZE];
  logic [DATA_W-1:0] m_vj   [RS_SIZE];
  logic [TAG_W-1:0]  m_qj   [RS_SIZE];
  bit                m_rj   [RS_SIZE];
  logic [DATA_W-1:0] m_vk   [RS_SIZE];
  logic [TAG_W-1:0]  m_qk   [RS_SIZE];
  bit                m_rk   [RS_SIZE];
  logic [TAG_W-1:0]  m_dest [RS_SIZE];
  logic              exp_status, exp_full;
  logic [OP_W-1:0]   exp_op;
  logic [DATA_W-1:0] exp_rs1, exp_rs2;
  logic [TAG_W-1:0]  exp_rob;

  function automatic logic [32:0] snoop(input logic rdy, input logic [TAG_W-1:0] tag,
                                        input logic [DATA_W-1:0] val);
    if (rdy) return {1'b1, val};
    if (alu_cdb_valid && alu_cdb_tag == tag) return {1'b1, alu_cdb_val};
    if (lsb_cdb_valid && lsb_cdb_tag == tag) return {1'b1, lsb_cdb_val};
    return {1'b0, val};
  endfunction

  always @(posedge clk_in) begin : model_p
    int d;
    int f;
    if (!rst_in) begin
      for (int i = 0; i < RS_SIZE; i++) m_busy[i] = 1'b0;
      exp_status = 1'b0; exp_full = 1'b0;
      exp_op = '0; exp_rs1 = '0; exp_rs2 = '0; exp_rob = '0;
    end else if (clear) begin
      for (int i = 0; i < RS_SIZE; i++) m_busy[i] = 1'b0;
      exp_status = 1'b0; exp_full = 1'b0;
    end else if (rdy_in) begin
      d = -1; f = -1;
      for (int i = RS_SIZE - 1; i >= 0; i--) begin
        if (m_busy[i] && m_rj[i] && m_rk[i]) d = i;
        if (!m_busy[i]) f = i;
      end
      exp_status = (d >= 0);
      if (d >= 0) begin
        exp_op = m_op[d]; exp_rs1 = m_vj[d]; exp_rs2 = m_vk[d]; exp_rob = m_dest[d];
        m_busy[d] = 1'b0;
      end
      for (int i = 0; i < RS_SIZE; i++) begin
        if (m_busy[i]) begin
          {m_rj[i], m_vj[i]} = snoop(m_rj[i], m_qj[i], m_vj[i]);
          {m_rk[i], m_vk[i]} = snoop(m_rk[i], m_qk[i], m_vk[i]);
        end
      end
      if (issue_valid && f >= 0) begin
        m_busy[f] = 1'b1; m_op[f] = issue_op; m_dest[f] = issue_dest;
        m_qj[f] = issue_qj; m_qk[f] = issue_qk;
        {m_rj[f], m_vj[f]} = snoop(!issue_qj_busy, issue_qj, issue_vj);
        {m_rk[f], m_vk[f]} = snoop(!issue_qk_busy, issue_qk, issue_vk);
      end
      exp_full = 1'b1;
      for (int i = 0; i < RS_SIZE; i++) if (!m_busy[i]) exp_full = 1'b0;
    end
    #1;
    if (rst_in) begin
      check("model_status", {31'd0, alu_status}, {31'd0, exp_status});
      check("model_full",   {31'd0, rs_full},    {31'd0, exp_full});
      check("model_op",     {26'd0, alu_op},     {26'd0, exp_op});
      check("model_rs1",    alu_rs1,             exp_rs1);
      check("model_rs2",    alu_rs2,             exp_rs2);
      check("model_rob",    {27'd0, alu_rob},    {27'd0, exp_rob});
    end
  end

  task automatic step();
    @(posedge clk_in);
    #2;
  endtask

  task automatic idle();
    issue_valid = 1'b0; issue_op = '0; issue_vj = '0; issue_qj = '0; issue_qj_busy = 1'b0;
    issue_vk = '0; issue_qk = '0; issue_qk_busy = 1'b0; issue_dest = '0;
    alu_cdb_valid = 1'b0; alu_cdb_tag = '0; alu_cdb_val = '0;
    lsb_cdb_valid = 1'b0; lsb_cdb_tag = '0; lsb_cdb_val = '0;
    clear = 1'b0;
  endtask

  task automatic do_issue(input logic [OP_W-1:0] op, input logic [31:0] vj,
                          input logic [4:0] qj, input logic qjb, input logic [31:0] vk,
                          input logic [4:0] qk, input logic qkb, input logic [4:0] dest);
    issue_valid = 1'b1; issue_op = op; issue_vj = vj; issue_qj = qj; issue_qj_busy = qjb;
    issue_vk = vk; issue_qk = qk; issue_qk_busy = qkb; issue_dest = dest;
  endtask

  initial begin
    idle();
    rst_in = 1'b0; rdy_in = 1'b1;
    repeat (3) step();
    check("reset_status", {31'd0, alu_status}, 32'd0);
    check("reset_full",   {31'd0, rs_full},    32'd0);
    check("reset_op",     {26'd0, alu_op},     32'd0);
    check("reset_rs1",    alu_rs1,             32'd0);
    check("reset_rob",    {27'd0, alu_rob},    32'd0);
    rst_in = 1'b1;
    step();

    // Both operands ready: dispatch on the following edge, status for one cycle.
    do_issue(OP_ADDI, 32'd5, 5'd0, 1'b0, 32'd7, 5'd0, 1'b0, 5'd3);
    step(); idle(); step();
    check("t1_status", {31'd0, alu_status}, 32'd1);
    check("t1_rs1", alu_rs1, 32'd5);
    check("t1_rs2", alu_rs2, 32'd7);
    check("t1_rob", {27'd0, alu_rob}, 32'd3);
    check("t1_op",  {26'd0, alu_op}, {26'd0, OP_ADDI});
    step();
    check("t1_status_drop", {31'd0, alu_status}, 32'd0);

    // Wakeup from ALU CDB, dispatch one edge after the wakeup edge.
    do_issue(OP_ADD, 32'hdead, 5'd2, 1'b1, 32'd1, 5'd0, 1'b0, 5'd6);
    step(); idle(); step(); step();
    alu_cdb_valid = 1'b1; alu_cdb_tag = 5'd2; alu_cdb_val = 32'h10;
    step(); idle();
    check("t2_no_bypass", {31'd0, alu_status}, 32'd0);
    step();
    check("t2_status", {31'd0, alu_status}, 32'd1);
    check("t2_rs1", alu_rs1, 32'h10);
    check("t2_rs2", alu_rs2, 32'd1);

    // Issue-time forwarding from the LSB bus.
    do_issue(OP_ADD, 32'd8, 5'd0, 1'b0, 32'd0, 5'd4, 1'b1, 5'd9);
    lsb_cdb_valid = 1'b1; lsb_cdb_tag = 5'd4; lsb_cdb_val = 32'd9;
    step(); idle(); step();
    check("t3_status", {31'd0, alu_status}, 32'd1);
    check("t3_rs2", alu_rs2, 32'd9);
    check("t3_rob", {27'd0, alu_rob}, 32'd9);

    // Fill all entries, drop an overflow issue, then drain in index order.
    for (int i = 0; i < RS_SIZE; i++) begin
      do_issue(OP_ADD, 32'd0, 5'd7, 1'b1, 32'(100 + i), 5'd0, 1'b0, 5'(i));
      step();
    end
    check("t4_full", {31'd0, rs_full}, 32'd1);
    do_issue(OP_SUB, 32'd1, 5'd0, 1'b0, 32'd2, 5'd0, 1'b0, 5'd31);
    step(); idle();
    check("t4_full_after_drop", {31'd0, rs_full}, 32'd1);
    alu_cdb_valid = 1'b1; alu_cdb_tag = 5'd7; alu_cdb_val = 32'h77;
    step(); idle();
    check("t4_no_bypass", {31'd0, alu_status}, 32'd0);
    for (int i = 0; i < RS_SIZE; i++) begin
      step();
      check("t4_drain_status", {31'd0, alu_status}, 32'd1);
      check("t4_drain_rob", {27'd0, alu_rob}, 32'(i));
      check("t4_drain_rs2", alu_rs2, 32'(100 + i));
      if (i == 0) check("t4_full_fall", {31'd0, rs_full}, 32'd0);
    end
    step();
    check("t4_dropped_never_dispatched", {31'd0, alu_status}, 32'd0);

    // Clear flushes pending entries and discards the same-cycle issue.
    for (int i = 0; i < 5; i++) begin
      do_issue(OP_ADD, 32'd0, 5'd9, 1'b1, 32'd0, 5'd12, 1'b1, 5'(i));
      step();
    end
    do_issue(OP_ADDI, 32'd1, 5'd0, 1'b0, 32'd2, 5'd0, 1'b0, 5'd30);
    clear = 1'b1;
    step(); idle();
    check("t5_status", {31'd0, alu_status}, 32'd0);
    check("t5_full", {31'd0, rs_full}, 32'd0);
    alu_cdb_valid = 1'b1; alu_cdb_tag = 5'd9;
    lsb_cdb_valid = 1'b1; lsb_cdb_tag = 5'd12;
    step(); idle(); step();
    check("t5_stale_cdb", {31'd0, alu_status}, 32'd0);
    step();
    check("t5_stale_cdb2", {31'd0, alu_status}, 32'd0);

    // rdy_in low freezes dispatch and ignores CDB traffic.
    do_issue(OP_ADD, 32'd0, 5'd11, 1'b1, 32'd5, 5'd0, 1'b0, 5'd20);
    step();
    do_issue(OP_ADDI, 32'd3, 5'd0, 1'b0, 32'd4, 5'd0, 1'b0, 5'd21);
    step(); idle(); rdy_in = 1'b0;
    step();
    check("t6_frozen0", {31'd0, alu_status}, 32'd0);
    alu_cdb_valid = 1'b1; alu_cdb_tag = 5'd11; alu_cdb_val = 32'h55;
    step(); idle();
    check("t6_frozen1", {31'd0, alu_status}, 32'd0);
    step();
    check("t6_frozen2", {31'd0, alu_status}, 32'd0);
    rdy_in = 1'b1;
    step();
    check("t6_status", {31'd0, alu_status}, 32'd1);
    check("t6_rob", {27'd0, alu_rob}, 32'd21);
    check("t6_rs1", alu_rs1, 32'd3);
    step();
    check("t6_cdb_ignored", {31'd0, alu_status}, 32'd0);
    alu_cdb_valid = 1'b1; alu_cdb_tag = 5'd11; alu_cdb_val = 32'h66;
    step(); idle(); step();
    check("t6_late_status", {31'd0, alu_status}, 32'd1);
    check("t6_late_rob", {27'd0, alu_rob}, 32'd20);
    check("t6_late_rs1", alu_rs1, 32'h66);

    // Randomized traffic; the model compare process checks every cycle.
    for (int n = 0; n < 3000; n++) begin
      issue_valid   = ($urandom_range(0, 99) < 60);
      issue_op      = 6'($urandom_range(0, 63));
      issue_vj      = $urandom;
      issue_qj      = 5'($urandom_range(0, 7));
      issue_qj_busy = ($urandom_range(0, 2) == 0);
      issue_vk      = $urandom;
      issue_qk      = 5'($urandom_range(0, 7));
      issue_qk_busy = ($urandom_range(0, 2) == 0);
      issue_dest    = 5'($urandom_range(0, 31));
      alu_cdb_valid = ($urandom_range(0, 99) < 40);
      alu_cdb_tag   = 5'($urandom_range(0, 7));
      alu_cdb_val   = $urandom;
      lsb_cdb_valid = ($urandom_range(0, 99) < 30);
      lsb_cdb_tag   = 5'($urandom_range(0, 7));
      lsb_cdb_val   = $urandom;
      if (alu_cdb_valid && lsb_cdb_valid && alu_cdb_tag == lsb_cdb_tag)
        lsb_cdb_tag = lsb_cdb_tag ^ 5'd1;
      clear  = ($urandom_range(0, 199) == 0);
      rdy_in = ($urandom_range(0, 9) != 0);
      step();
    end
    idle(); rdy_in = 1'b1;
    repeat (5) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
